// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader slice.
package fifo_burst_reader_pkg;

    localparam int unsigned FIFO_WIDTH = 16;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_STREAM,
        RD_DRAIN,
        RD_TRAILER
    } rd_state_e;

    typedef struct packed {
        logic [FIFO_WIDTH-1:0] data;
        logic                  sop;
        logic                  eop;
        logic                  short_b;
    } stream_beat_t;

    // Room for one more word once this cycle's outgoing transfer is accounted for.
    function automatic logic buf_has_space(input logic [1:0] occ,
                                           input logic       inflight,
                                           input logic       xfer);
        logic [1:0] held;
        held = occ + {1'b0, inflight} - {1'b0, xfer};
        return (held < 2'd2);
    endfunction

endpackage

// File: rtl/fifo_burst_reader_skid_buf.sv
// Two-entry output buffer; head entry drives the stream and holds under stall.
module stream_skid_buf
    import fifo_burst_reader_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  stream_beat_t in_beat,
    output logic         out_valid,
    input  logic         out_ready,
    output stream_beat_t out_beat,
    output logic [1:0]   occ
);

    stream_beat_t ent0;
    stream_beat_t ent1;
    logic [1:0]   cnt;
    logic         pop;

    assign pop       = out_valid && out_ready;
    assign out_valid = (cnt != 2'd0);
    assign out_beat  = ent0;
    assign occ       = cnt;

    // Shift-register buffer: push fills the first free slot, pop advances the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0 <= '0;
            ent1 <= '0;
            cnt  <= '0;
        end else begin
            case ({in_valid, pop})
                2'b10: begin
                    if (cnt == 2'd0) ent0 <= in_beat;
                    else             ent1 <= in_beat;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        ent0 <= in_beat;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= in_beat;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && !pop) |-> (cnt != 2'd2));
`endif

endmodule

// File: rtl/fifo_burst_reader.sv
// FIFO read-side consumer: pops words, streams them in bursts closed by an
// XOR checksum trailer, with early close when the FIFO idles too long.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned TIMEOUT   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic                  m_short,
    output logic                  err_underflow,
    output logic                  busy
);

    localparam logic [7:0] BURST_LEN_C = 8'(BURST_LEN);
    localparam logic [7:0] TIMEOUT_C   = 8'(TIMEOUT);

    rd_state_e             state;
    rd_state_e             state_n;
    logic [7:0]            popcnt;
    logic [7:0]            idle_cnt;
    logic [FIFO_WIDTH-1:0] chk;
    logic                  inflight;
    logic                  first_cap;
    logic                  short_r;
    logic                  short_n;

    logic                  space;
    logic                  permit;
    logic                  idle_pop;
    logic                  push_valid;
    stream_beat_t          push_beat;
    stream_beat_t          out_beat;
    logic [1:0]            occ;

    // Space counts a beat leaving this cycle so a steady stream runs at one word per clock.
    assign space      = buf_has_space(occ, inflight, m_valid && m_ready);
    assign permit     = (state == RD_IDLE) ||
                        ((state == RD_STREAM) && (popcnt < BURST_LEN_C) && (idle_cnt < TIMEOUT_C));
    assign fifo_rd_en = rst_n && !fifo_empty && space && permit;
    assign idle_pop   = (state == RD_IDLE) && fifo_rd_en;

    // Next-state logic and buffer push selection.
    always_comb begin
        state_n    = state;
        short_n    = short_r;
        push_valid = 1'b0;
        push_beat  = '0;
        case (state)
            RD_IDLE: begin
                if (fifo_rd_en) state_n = RD_STREAM;
            end
            RD_STREAM: begin
                if (popcnt == BURST_LEN_C) begin
                    state_n = RD_DRAIN;
                    short_n = 1'b0;
                end else if (idle_cnt == TIMEOUT_C) begin
                    state_n = RD_DRAIN;
                    short_n = 1'b1;
                end
            end
            RD_DRAIN: begin
                if (!inflight) state_n = RD_TRAILER;
            end
            RD_TRAILER: begin
                if (space) state_n = RD_IDLE;
            end
            default: state_n = RD_IDLE;
        endcase
        if (inflight) begin
            push_valid = 1'b1;
            push_beat  = '{data: fifo_data_out, sop: first_cap, eop: 1'b0, short_b: 1'b0};
        end else if ((state == RD_TRAILER) && space) begin
            push_valid = 1'b1;
            push_beat  = '{data: chk, sop: 1'b0, eop: 1'b1, short_b: short_r};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RD_IDLE;
        else        state <= state_n;
    end

    // Burst counters, checksum, read-latency tracking and sticky underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            popcnt        <= '0;
            idle_cnt      <= '0;
            chk           <= '0;
            inflight      <= 1'b0;
            first_cap     <= 1'b0;
            short_r       <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            short_r  <= short_n;
            if (fifo_underflow) err_underflow <= 1'b1;

            if (idle_pop)      chk <= '0;
            else if (inflight) chk <= chk ^ fifo_data_out;

            if (idle_pop)      first_cap <= 1'b1;
            else if (inflight) first_cap <= 1'b0;

            if (idle_pop)                                 popcnt <= 8'd1;
            else if ((state == RD_STREAM) && fifo_rd_en) popcnt <= popcnt + 8'd1;

            if (idle_pop || ((state == RD_STREAM) && fifo_rd_en))
                idle_cnt <= '0;
            else if ((state == RD_STREAM) && fifo_empty && (idle_cnt != TIMEOUT_C))
                idle_cnt <= idle_cnt + 8'd1;
        end
    end

    stream_skid_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (push_valid),
        .in_beat   (push_beat),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_beat  (out_beat),
        .occ       (occ)
    );

    assign m_data  = out_beat.data;
    assign m_sop   = out_beat.sop;
    assign m_eop   = out_beat.eop;
    assign m_short = out_beat.short_b;
    assign busy    = (state != RD_IDLE);

`ifndef SYNTHESIS
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_empty |-> !fifo_rd_en);
    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_sop) &&
                                   $stable(m_eop) && $stable(m_short)));
    a_eop_not_sop:  assert property (@(posedge clk) disable iff (!rst_n)
        m_eop |-> !m_sop);
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed, table-driven bench for fifo_burst_reader with a registered-read FIFO model.
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_rd_en;
    logic        fifo_empty;
    logic [15:0] fifo_data_out = '0;
    logic        fifo_underflow;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_sop;
    logic        m_eop;
    logic        m_short;
    logic        err_underflow;
    logic        busy;

    fifo_burst_reader #(.BURST_LEN(4), .TIMEOUT(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_empty     (fifo_empty),
        .fifo_data_out  (fifo_data_out),
        .fifo_underflow (fifo_underflow),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_sop          (m_sop),
        .m_eop          (m_eop),
        .m_short        (m_short),
        .err_underflow  (err_underflow),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // FIFO model: bench writes mem/wr_ptr, read side advances rd_ptr on a pop.
    logic [15:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data_out <= mem[rd_ptr % 256];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every stream transfer with the cycle it happened in.
    logic [15:0] rx_data  [0:255];
    logic        rx_sop   [0:255];
    logic        rx_eop   [0:255];
    logic        rx_short [0:255];
    int          rx_cyc   [0:255];
    int          rx_wr = 0;

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            rx_data[rx_wr % 256]  <= m_data;
            rx_sop[rx_wr % 256]   <= m_sop;
            rx_eop[rx_wr % 256]   <= m_eop;
            rx_short[rx_wr % 256] <= m_short;
            rx_cyc[rx_wr % 256]   <= cyc;
            rx_wr                 <= rx_wr + 1;
        end
    end

    typedef struct {
        logic        push;
        logic [15:0] word;
        logic [15:0] exp_data;
        logic        exp_sop;
        logic        exp_eop;
        logic        exp_short;
    } vec_t;

    vec_t vecs [0:22];
    int   checks   = 0;
    int   failures = 0;
    int   rx_rd    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        mem[wr_ptr % 256] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_beats(input int n);
        for (int k = 0; k < 200 && (rx_wr - rx_rd) < n; k++) step();
        check("beat_wait", 32'((rx_wr - rx_rd) >= n), 32'd1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (k < 300 && (busy || m_valid || !fifo_empty)) begin
            step();
            k++;
        end
        repeat (2) step();
        check("idle_wait", 32'(k < 300), 32'd1);
    endtask

    task automatic load_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            if (vecs[i].push) push_word(vecs[i].word);
    endtask

    task automatic check_table(input int lo, input int hi);
        wait_beats(hi - lo + 1);
        for (int i = lo; i <= hi; i++) begin
            int idx;
            idx = rx_rd % 256;
            check($sformatf("v%0d_data", i),  32'(rx_data[idx]),  32'(vecs[i].exp_data));
            check($sformatf("v%0d_sop", i),   32'(rx_sop[idx]),   32'(vecs[i].exp_sop));
            check($sformatf("v%0d_eop", i),   32'(rx_eop[idx]),   32'(vecs[i].exp_eop));
            check($sformatf("v%0d_short", i), 32'(rx_short[idx]), 32'(vecs[i].exp_short));
            if (i > lo && !vecs[i].exp_sop && !vecs[i].exp_eop)
                check($sformatf("v%0d_gap", i), 32'(rx_cyc[idx] - rx_cyc[(rx_rd - 1) % 256]), 32'd1);
            rx_rd++;
        end
    endtask

    initial begin
        int rd_c;
        int mv_c;
        int base;
        int gap;

        rst_n          = 1'b0;
        m_ready        = 1'b0;
        fifo_underflow = 1'b0;

        // Test 2: 1..4, checksum 1^2^3^4 = 4
        vecs[0]  = '{1'b1, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 16'h0004, 16'h0004, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 16'h0004, 1'b0, 1'b1, 1'b0};
        // Test 3: two back-to-back bursts
        vecs[5]  = '{1'b1, 16'h1111, 16'h1111, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 16'h2222, 16'h2222, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 16'h4444, 16'h4444, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 16'h8888, 16'h8888, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 16'hA5A5, 16'hA5A5, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 16'h0F0F, 16'h0F0F, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 16'h0000, 16'hE2C4, 1'b0, 1'b1, 1'b0};
        // Test 4: timeout short burst
        vecs[15] = '{1'b1, 16'h00F0, 16'h00F0, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 16'h000F, 16'h000F, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 16'h0000, 16'h00FF, 1'b0, 1'b1, 1'b1};
        // Test 5: stalled burst
        vecs[18] = '{1'b1, 16'h0C01, 16'h0C01, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 16'h0C02, 16'h0C02, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 16'h0C03, 16'h0C03, 1'b0, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 16'h0C04, 16'h0C04, 1'b0, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 16'h0000, 16'h0004, 1'b0, 1'b1, 1'b0};

        repeat (3) step();
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_err",   32'(err_underflow), 32'd0);
        rst_n = 1'b1;
        step();

        // Test 1: asynchronous reset in the middle of a burst
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(16'h0100 + 16'(i));
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("arst_valid", 32'(m_valid), 32'd0);
        check("arst_data",  32'(m_data), 32'd0);
        check("arst_sop",   32'(m_sop), 32'd0);
        check("arst_eop",   32'(m_eop), 32'd0);
        check("arst_short", 32'(m_short), 32'd0);
        check("arst_busy",  32'(busy), 32'd0);
        check("arst_err",   32'(err_underflow), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        rx_rd = rx_wr;
        wait_beats(1);
        check("post_rst_sop", 32'(rx_sop[rx_rd % 256]), 32'd1);
        wait_idle();
        rx_rd = rx_wr;

        // Test 2: single burst plus latency from first pop to first valid
        load_table(0, 4);
        rd_c = -1;
        mv_c = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fifo_rd_en && rd_c < 0) rd_c = cyc;
            if (m_valid && mv_c < 0)    mv_c = cyc;
        end
        check("first_rd_seen", 32'(rd_c >= 0), 32'd1);
        check("latency", 32'(mv_c - rd_c), 32'd2);
        check_table(0, 4);
        wait_idle();

        // Test 3: two back-to-back full bursts
        load_table(5, 14);
        check_table(5, 14);
        wait_idle();

        // Test 4: early close after the FIFO goes idle
        load_table(15, 17);
        check_table(15, 17);
        gap = rx_cyc[(rx_rd - 1) % 256] - rx_cyc[(rx_rd - 2) % 256];
        check("timeout_gap", 32'(gap >= 8), 32'd1);
        wait_idle();

        // Test 5: sink stall holds pops at two outstanding words
        m_ready = 1'b0;
        base = rd_ptr;
        load_table(18, 22);
        repeat (10) step();
        check("stall_rd_en", 32'(fifo_rd_en), 32'd0);
        check("stall_pops",  32'(rd_ptr - base), 32'd2);
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data",  32'(m_data), 32'h0C01);
        check("stall_sop",   32'(m_sop), 32'd1);
        m_ready = 1'b1;
        check_table(18, 22);
        wait_idle();
        check("no_extra_beats", 32'(rx_wr - rx_rd), 32'd0);

        // Test 6: sticky underflow flag cleared only by reset
        fifo_underflow = 1'b1;
        step();
        fifo_underflow = 1'b0;
        check("uf_set", 32'(err_underflow), 32'd1);
        repeat (5) step();
        check("uf_sticky", 32'(err_underflow), 32'd1);
        rst_n = 1'b0;
        #1;
        check("uf_rst", 32'(err_underflow), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("uf_after_rst", 32'(err_underflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
